// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   mem_size_t  : decoded access width (byte / half / word)
//   mem_state_t : load/store sequencer states
//   WORD_W      : datapath width
//   decode_size : raw 2-bit size field -> mem_size_t (reserved 11 reads as word)
//   is_aligned  : natural alignment check for a given width and byte offset
//   byte_strobe : byte-lane enables for a given width and byte offset
package mem_access_stage_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MS_BYTE = 2'b00,
    MS_HALF = 2'b01,
    MS_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  function automatic mem_size_t decode_size(input logic [1:0] raw);
    mem_size_t sz;
    case (raw)
      2'b00:   sz = MS_BYTE;
      2'b01:   sz = MS_HALF;
      default: sz = MS_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_aligned(input mem_size_t sz, input logic [1:0] off);
    logic ok;
    case (sz)
      MS_BYTE: ok = 1'b1;
      MS_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_strobe(input mem_size_t sz, input logic [1:0] off);
    logic [3:0] strb;
    case (sz)
      MS_BYTE: strb = 4'b0001 << off;
      MS_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load alignment and extension. Selects the addressed byte or halfword
// from a memory word and sign- or zero-extends it; words pass through.
// Purely combinational so the writeback bypass path can reuse it.
//   i_rdata    : raw memory word
//   i_offset   : byte offset within the word (address bits [1:0])
//   i_size     : raw size field (00 byte, 01 half, 1x word)
//   i_unsigned : zero-extend instead of sign-extend
//   o_data     : extended 32-bit load value
module mem_access_stage_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[8*i_offset +: 8];
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (decode_size(i_size))
      MS_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      MS_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit. Turns the EX/MEM load/store controls into a
// ready-handshaked data-memory transaction, stalls the pipeline until it
// completes, and delivers the aligned/extended load result to MEM/WB.
//   i_clk, i_rst_n        : pipeline clock, async active-low reset
//   i_mem_read/_write     : load / store request (both set = store)
//   i_mem_size            : 00 byte, 01 half, 1x word
//   i_mem_unsigned        : zero-extend loads
//   i_alu_result          : effective byte address
//   i_store_data          : store data, low-aligned
//   o_dmem_req/_we/_addr/_wdata/_wstrb, i_dmem_rdata, i_dmem_ready : memory port
//   o_read_data           : extended load result (0 after a store)
//   o_stall               : freeze earlier stages
//   o_misaligned_exc      : one-cycle pulse on a misaligned access
//   o_bus_err             : one-cycle pulse when the request times out
//
// state | meaning
// IDLE  | waiting for an access; latches the request on an aligned access
// REQ   | request on the bus, waiting for ready or timeout
// DONE  | result valid, stall released for one cycle
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ready,
  output logic [31:0] o_read_data,
  output logic        o_stall,
  output logic        o_misaligned_exc,
  output logic        o_bus_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_we;
  logic [31:0]       r_read_data;
  logic              r_misaligned;
  logic              r_bus_err;

  mem_size_t         w_size;
  logic              w_access;
  logic              w_aligned;
  logic              w_start;
  logic              w_misaligned;
  logic              w_timeout;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  assign w_size       = decode_size(i_mem_size);
  assign w_access     = i_mem_read | i_mem_write;
  assign w_aligned    = is_aligned(w_size, i_alu_result[1:0]);
  assign w_start      = (r_state == IDLE) & w_access & w_aligned;
  assign w_misaligned = (r_state == IDLE) & w_access & ~w_aligned;
  assign w_cnt_nxt    = r_cnt + 1'b1;
  // A TIMEOUT of 0 leaves the request waiting on ready forever.
  assign w_timeout    = (TIMEOUT != 0) && (w_cnt_nxt == TIMEOUT_CNT);

  always_comb begin
    case (w_size)
      MS_BYTE: w_wdata = {4{i_store_data[7:0]}};
      MS_HALF: w_wdata = {2{i_store_data[15:0]}};
      default: w_wdata = i_store_data;
    endcase
  end

  mem_access_stage_load_align u_load_align (
    .i_rdata    (i_dmem_rdata),
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = REQ;
      REQ:     if (i_dmem_ready || w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stall is gated by reset so a held access cannot freeze the pipe while
  // the unit itself is being reset.
  always_comb begin
    o_stall      = i_rst_n & w_access & w_aligned & (r_state != DONE);
    o_dmem_req   = (r_state == REQ);
    o_dmem_we    = (r_state == REQ) & r_we;
    o_dmem_wstrb = (r_state == REQ) ? r_wstrb : 4'b0000;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_we         <= 1'b0;
      r_read_data  <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr     <= i_alu_result;
        r_wdata    <= w_wdata;
        r_wstrb    <= i_mem_write ? byte_strobe(w_size, i_alu_result[1:0]) : 4'b0000;
        r_size     <= i_mem_size;
        r_unsigned <= i_mem_unsigned;
        r_we       <= i_mem_write;
      end

      r_cnt        <= ((r_state == REQ) && (w_state_nxt == REQ)) ? w_cnt_nxt : '0;
      r_misaligned <= w_misaligned;
      r_bus_err    <= (r_state == REQ) & ~i_dmem_ready & w_timeout;

      if (w_misaligned) begin
        r_read_data <= '0;
      end else if (r_state == REQ) begin
        if (i_dmem_ready)   r_read_data <= r_we ? 32'h0 : w_load_data;
        else if (w_timeout) r_read_data <= '0;
      end
    end
  end

  assign o_dmem_addr      = {r_addr[31:2], 2'b00};
  assign o_dmem_wdata     = r_wdata;
  assign o_read_data      = r_read_data;
  assign o_misaligned_exc = r_misaligned;
  assign o_bus_err        = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TO_BIG   = 255;
  localparam int TO_SMALL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, uns, sel_to;
  logic [1:0]  size;
  logic [31:0] addr, sd, rdata;
  logic        ready;

  logic        m_req, m_we, m_stall, m_mis, m_berr;
  logic [31:0] m_addr, m_wdata, m_rdd;
  logic [3:0]  m_strb;
  logic        t_req, t_we, t_stall, t_mis, t_berr;
  logic [31:0] t_addr, t_wdata, t_rdd;
  logic [3:0]  t_strb;

  logic        req, we, stall, mis, berr;
  logic [31:0] daddr, wdata, read_data;
  logic [3:0]  strb;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] hold_m = 0;
  logic [31:0] hold_t = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO_BIG)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_read(rd & ~sel_to), .i_mem_write(wr & ~sel_to),
    .i_mem_size(size), .i_mem_unsigned(uns),
    .i_alu_result(addr), .i_store_data(sd),
    .o_dmem_req(m_req), .o_dmem_we(m_we), .o_dmem_addr(m_addr),
    .o_dmem_wdata(m_wdata), .o_dmem_wstrb(m_strb),
    .i_dmem_rdata(rdata), .i_dmem_ready(ready),
    .o_read_data(m_rdd), .o_stall(m_stall),
    .o_misaligned_exc(m_mis), .o_bus_err(m_berr)
  );

  mem_access_stage #(.TIMEOUT(TO_SMALL)) u_dut_to (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_read(rd & sel_to), .i_mem_write(wr & sel_to),
    .i_mem_size(size), .i_mem_unsigned(uns),
    .i_alu_result(addr), .i_store_data(sd),
    .o_dmem_req(t_req), .o_dmem_we(t_we), .o_dmem_addr(t_addr),
    .o_dmem_wdata(t_wdata), .o_dmem_wstrb(t_strb),
    .i_dmem_rdata(rdata), .i_dmem_ready(ready),
    .o_read_data(t_rdd), .o_stall(t_stall),
    .o_misaligned_exc(t_mis), .o_bus_err(t_berr)
  );

  assign req       = sel_to ? t_req   : m_req;
  assign we        = sel_to ? t_we    : m_we;
  assign stall     = sel_to ? t_stall : m_stall;
  assign mis       = sel_to ? t_mis   : m_mis;
  assign berr      = sel_to ? t_berr  : m_berr;
  assign daddr     = sel_to ? t_addr  : m_addr;
  assign wdata     = sel_to ? t_wdata : m_wdata;
  assign read_data = sel_to ? t_rdd   : m_rdd;
  assign strb      = sel_to ? t_strb  : m_strb;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference load result: pick the addressed bytes arithmetically and extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
    int nb;
    logic [31:0] mask, v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (nb == 4) return w;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v = (w >> (8 * (a % 4))) & mask;
    if (!u && (v > (mask >> 1))) v = v - (mask + 32'h1);
    return v;
  endfunction

  task automatic run_access(input bit use_to, input logic r, input logic w,
                            input logic [1:0] sz, input logic u, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rw, input int lat);
    int nb, lim, exp_req, n_stall, n_req, guard;
    bit aligned, tmo;
    logic [31:0] exp_rd, exp_strb, exp_wd;
    @(negedge clk);
    sel_to = use_to;
    rd = r; wr = w; size = sz; uns = u; addr = a; sd = d; ready = 1'b0;
    #1;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    aligned = ((a % nb) == 0);
    if (!aligned) begin
      chk("mis_stall0", stall, 0);
      chk("mis_req0", req, 0);
      @(negedge clk); #1;
      chk("mis_exc", mis, 1);
      chk("mis_rdata", read_data, 0);
      chk("mis_req1", req, 0);
      chk("mis_stall1", stall, 0);
      rd = 1'b0; wr = 1'b0;
      if (use_to) hold_t = 0; else hold_m = 0;
      @(negedge clk); #1;
      chk("mis_exc_clr", mis, 0);
      return;
    end
    lim      = use_to ? TO_SMALL : TO_BIG;
    tmo      = (lat < 0) || (lat >= lim);
    exp_req  = tmo ? lim : lat + 1;
    exp_strb = w ? (((1 << nb) - 1) << (a % 4)) : 0;
    exp_wd   = (nb == 1) ? d[7:0] * 32'h01010101 : (nb == 2) ? d[15:0] * 32'h00010001 : d;
    exp_rd   = (w || tmo) ? 32'h0 : ref_load(rw, a, sz, u);
    n_stall = 0; n_req = 0; guard = 0;
    chk("idle_req", req, 0);
    while (stall === 1'b1 && guard < 400) begin
      n_stall++;
      if (req === 1'b1) begin
        n_req++;
        if (n_req == 1) begin
          chk("dmem_addr", daddr, a & 32'hFFFF_FFFC);
          chk("dmem_we", we, w);
          chk("dmem_wstrb", strb, exp_strb);
          if (w) chk("dmem_wdata", wdata, exp_wd);
        end
        ready = (lat >= 0) && (n_req == lat + 1);
        rdata = ready ? rw : $urandom;
      end else begin
        ready = 1'b0;
      end
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 400) chk("cycle_budget", guard, 0);
    chk("stall_cycles", n_stall, exp_req + 1);
    chk("req_cycles", n_req, exp_req);
    chk("done_req", req, 0);
    chk("done_rdata", read_data, exp_rd);
    chk("done_bus_err", berr, tmo);
    ready = 1'b0; rd = 1'b0; wr = 1'b0;
    if (use_to) hold_t = exp_rd; else hold_m = exp_rd;
    @(negedge clk); #1;
    chk("post_bus_err", berr, 0);
    chk("post_req", req, 0);
    chk("post_rdata", read_data, exp_rd);
  endtask

  task automatic idle_check();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1;
    chk("hold_rdata", read_data, sel_to ? hold_t : hold_m);
    chk("idle_stall", stall, 0);
  endtask

  initial begin
    rst_n = 1'b0; rd = 0; wr = 0; uns = 0; size = 0; addr = 0; sd = 0;
    rdata = 0; ready = 0; sel_to = 0;
    #12;
    chk("rst_req", m_req, 0);
    chk("rst_we", m_we, 0);
    chk("rst_strb", m_strb, 0);
    chk("rst_rdata", m_rdd, 0);
    chk("rst_mis", m_mis, 0);
    chk("rst_berr", m_berr, 0);
    chk("rst_to_req", t_req, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_access(0, 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_access(0, 1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF0000, 1);
    run_access(0, 1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF0000, 0);
    run_access(0, 0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'h0, 0);
    idle_check();
    run_access(0, 1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0);
    run_access(1, 1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h55AA55AA, -1);
    run_access(1, 1, 0, 2'b01, 0, 32'h306, 32'h0, 32'h8001_7FFF, 3);
    run_access(0, 1, 1, 2'b11, 0, 32'h400, 32'hCAFEF00D, 32'h0, 2);
    idle_check();

    // Reset while a load is waiting on ready.
    @(negedge clk);
    sel_to = 0; rd = 1; wr = 0; size = 2'b10; uns = 0; addr = 32'h40; ready = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", m_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", m_req, 0);
    chk("async_stall_drop", m_stall, 0);
    chk("async_rdata", m_rdd, 0);
    rd = 0;
    hold_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", m_req, 0);
    run_access(0, 1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h13579BDF, 4);

    for (int i = 0; i < 60; i++) begin
      int op;
      logic r, w;
      op = $urandom_range(0, 3);
      r = (op != 1);
      w = (op != 0);
      if (op == 3) r = 1;
      run_access($urandom_range(0, 3) == 0, r, w, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) idle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1);
  end

endmodule
